// File: rtl/vga_pkg.sv
// Shared timing presets and helpers for the raster timing generator.
// Presets cover 640x480@60 and 800x600@60; the test-pattern bar colours live here as well.
package vga_pkg;

  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BP     = 23;

  localparam int NUM_BARS = 8;

  // Keeps counters at least one bit wide even for degenerate sizes.
  function automatic int clog2_safe(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

  // RGB 4:4:4, bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [11:0] bar_colour(input logic [2:0] idx);
    logic [11:0] c;
    case (idx)
      3'd0:    c = 12'hFFF;
      3'd1:    c = 12'hFF0;
      3'd2:    c = 12'h0FF;
      3'd3:    c = 12'h0F0;
      3'd4:    c = 12'hF0F;
      3'd5:    c = 12'hF00;
      3'd6:    c = 12'h00F;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Clock-enabled shift register that lines sync/DE (and pixel data) up with frame-buffer latency.
// DEPTH=0 degenerates to a wire; the caller already registers the input.
module vga_delay_line #(
  parameter int             W       = 1,
  parameter int             DEPTH   = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_ce,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  if (DEPTH == 0) begin : g_pass
    logic w_unused;
    assign w_unused = ^{clk, reset, i_ce};
    assign o_q      = i_d;
  end else begin : g_shift
    logic [W-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
      end else if (i_ce) begin
        r_stage[0] <= i_d;
        for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
    end

    assign o_q = r_stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel divider, x/y counters, sync/DE decode and delay.
// Define VGA_TPG_EN to add the o_tpg_rgb colour-bar test pattern aligned with o_de.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FP     = VGA640_H_FP,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BP     = VGA640_H_BP,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FP     = VGA640_V_FP,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BP     = VGA640_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 1,
  parameter int PIPE     = 2,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = clog2_safe(H_TOTAL),
  localparam int VW      = clog2_safe(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_en,
  output logic          o_pix_ce,
  output logic [HW-1:0] o_x,
  output logic [VW-1:0] o_y,
  output logic          o_fetch,
  output logic          o_h_sync,
  output logic          o_v_sync,
  output logic          o_de,
  output logic          o_line_start,
  output logic          o_frame_start
`ifdef VGA_TPG_EN
  ,
  output logic [11:0]   o_tpg_rgb
`endif
);

  localparam int DW       = clog2_safe(CLK_DIV);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
  localparam logic [2:0] DLY_IDLE = {~HS_POL, ~VS_POL, 1'b0};

  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_geom
    $fatal(1, "vga_timing_gen: porch and sync widths must be at least 1");
  end
  if (CLK_DIV < 1 || CLK_DIV > 8) begin : g_bad_div
    $fatal(1, "vga_timing_gen: CLK_DIV must be 1..8");
  end
  if (PIPE < 0 || PIPE > 7) begin : g_bad_pipe
    $fatal(1, "vga_timing_gen: PIPE must be 0..7");
  end

  logic [DW-1:0] r_div;
  logic          r_pix_ce;
  logic [HW-1:0] r_x;
  logic [VW-1:0] r_y;
  logic          r_hs0;
  logic          r_vs0;
  logic          r_fetch;
  logic          r_line_start;
  logic          r_frame_start;

  logic          w_tick;
  logic          w_x_last;
  logic          w_y_last;
  logic [HW-1:0] w_x_inc;
  logic [VW-1:0] w_y_inc;
  logic [HW-1:0] w_x_view;
  logic [VW-1:0] w_y_view;
  logic          w_hs_raw;
  logic          w_vs_raw;
  logic          w_fetch_raw;
  logic [2:0]    w_dly_q;

  assign w_tick = i_en && (r_div == DW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div    <= '0;
      r_pix_ce <= 1'b0;
    end else if (i_en) begin
      r_div    <= w_tick ? '0 : r_div + 1'b1;
      r_pix_ce <= w_tick;
    end else begin
      r_pix_ce <= 1'b0;
    end
  end

  assign w_x_last = (r_x == HW'(H_TOTAL - 1));
  assign w_y_last = (r_y == VW'(V_TOTAL - 1));
  assign w_x_inc  = w_x_last ? '0 : r_x + 1'b1;
  assign w_y_inc  = w_x_last ? (w_y_last ? '0 : r_y + 1'b1) : r_y;

  // The position finishes processing at the end of its pix_ce clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (r_pix_ce) begin
      r_x <= w_x_inc;
      r_y <= w_y_inc;
    end
  end

  // Decode from the position the counters hold after this edge so the flops line up with x/y.
  assign w_x_view    = r_pix_ce ? w_x_inc : r_x;
  assign w_y_view    = r_pix_ce ? w_y_inc : r_y;
  assign w_hs_raw    = (w_x_view >= HW'(HS_START)) && (w_x_view < HW'(HS_END));
  assign w_vs_raw    = (w_y_view >= VW'(VS_START)) && (w_y_view < VW'(VS_END));
  assign w_fetch_raw = (w_x_view < HW'(H_ACTIVE)) && (w_y_view < VW'(V_ACTIVE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hs0         <= ~HS_POL;
      r_vs0         <= ~VS_POL;
      r_fetch       <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (i_en || r_pix_ce) begin
      r_hs0         <= w_hs_raw ? HS_POL : ~HS_POL;
      r_vs0         <= w_vs_raw ? VS_POL : ~VS_POL;
      r_fetch       <= w_fetch_raw;
      r_line_start  <= w_tick && (w_x_view == '0);
      r_frame_start <= w_tick && (w_x_view == '0) && (w_y_view == '0);
    end
  end

  vga_delay_line #(
    .W       (3),
    .DEPTH   (PIPE),
    .RST_VAL (DLY_IDLE)
  ) u_sync_dly (
    .clk   (clk),
    .reset (reset),
    .i_ce  (r_pix_ce),
    .i_d   ({r_hs0, r_vs0, r_fetch}),
    .o_q   (w_dly_q)
  );

  assign o_pix_ce      = r_pix_ce;
  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_fetch       = r_fetch;
  assign o_h_sync      = w_dly_q[2];
  assign o_v_sync      = w_dly_q[1];
  assign o_de          = w_dly_q[0];
  assign o_line_start  = r_line_start;
  assign o_frame_start = r_frame_start;

`ifdef VGA_TPG_EN
  localparam int BAR_W = H_ACTIVE / NUM_BARS;

  if (BAR_W < 1) begin : g_bad_tpg
    $fatal(1, "vga_timing_gen: test pattern needs H_ACTIVE >= 8");
  end

  logic [11:0]   r_rgb0;
  logic [HW-1:0] w_bar;
  logic [2:0]    w_bar_idx;
  logic [11:0]   w_rgb_q;

  assign w_bar     = w_x_view / HW'(BAR_W);
  assign w_bar_idx = (w_bar > HW'(NUM_BARS - 1)) ? 3'd7 : w_bar[2:0];

  // Blanked at the source so the delayed colour is zero exactly when de is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rgb0 <= 12'h000;
    end else if (i_en || r_pix_ce) begin
      r_rgb0 <= w_fetch_raw ? bar_colour(w_bar_idx) : 12'h000;
    end
  end

  vga_delay_line #(
    .W       (12),
    .DEPTH   (PIPE),
    .RST_VAL (12'h000)
  ) u_rgb_dly (
    .clk   (clk),
    .reset (reset),
    .i_ce  (r_pix_ce),
    .i_d   (r_rgb0),
    .o_q   (w_rgb_q)
  );

  assign o_tpg_rgb = w_rgb_q;
`endif

endmodule
